// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and the lookup-width legality check
// used by the iterative InvSubBytes engine.
package aes_pkg;
    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_fsm_e;

    function automatic bit bpc_legal(input int bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8) || (bpc == 16);
    endfunction
endpackage

// File: rtl/aes_Sbox.sv
// AES forward S-box, only built when AES_INV_SUB_CHECK_EN is defined; it
// re-substitutes inverse results so the engine can self-check its lookups.
`ifdef AES_INV_SUB_CHECK_EN
module aes_Sbox (
    input  logic [7:0] sbox_in,
    output logic [7:0] aes128_sbox
);
    localparam logic [0:255][7:0] FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign aes128_sbox = FWD_TBL[sbox_in];
endmodule
`endif

// File: rtl/aes_inv_Sbox.sv
// AES inverse S-box: purely combinational 256-entry lookup, the counterpart
// of aes_Sbox.
module aes_inv_Sbox (
    input  logic [7:0] inv_sbox_in,
    output logic [7:0] aes128_inv_sbox
);
    localparam logic [0:255][7:0] INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign aes128_inv_sbox = INV_TBL[inv_sbox_in];
endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: BYTES_PER_CYCLE shared inverse S-boxes walk the
// state MSB chunk first. Optional self-check: define AES_INV_SUB_CHECK_EN.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy,
    output logic                   chk_err
);
    localparam int NUM_CHUNKS = 16 / BYTES_PER_CYCLE;
    localparam int CHUNK_W    = BYTES_PER_CYCLE * AES_BYTE_W;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    if (!bpc_legal(BYTES_PER_CYCLE)) begin : g_bad_bpc
        $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    aes_fsm_e               state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [AES_STATE_W-1:0] work_q, work_d, out_state_q;
    logic                   in_ready_q, out_valid_q, busy_q;
    logic [CHUNK_W-1:0]     cur_chunk, sub_chunk;

    // Chunk k sits at [127-k*CHUNK_W -: CHUNK_W]; a compare-per-chunk mux keeps
    // the select legal for every BYTES_PER_CYCLE including a single chunk.
    always_comb begin
        cur_chunk = '0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (cnt_q == CNT_W'(c))
                cur_chunk = work_q[AES_STATE_W-1-c*CHUNK_W -: CHUNK_W];
        end
    end

    always_comb begin
        work_d = work_q;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (cnt_q == CNT_W'(c))
                work_d[AES_STATE_W-1-c*CHUNK_W -: CHUNK_W] = sub_chunk;
        end
    end

    for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
        aes_inv_Sbox u_isb (
            .inv_sbox_in    (cur_chunk[b*AES_BYTE_W +: AES_BYTE_W]),
            .aes128_inv_sbox(sub_chunk[b*AES_BYTE_W +: AES_BYTE_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_state_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        work_q     <= in_state;
                        cnt_q      <= '0;
                        state_q    <= BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    // The final chunk goes straight into out_state with the rest.
                    if (cnt_q == LAST_CHUNK) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_state_q <= work_d;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;

`ifdef AES_INV_SUB_CHECK_EN
    logic [CHUNK_W-1:0] fwd_chunk;
    logic               chk_err_q;

    for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_chk
        aes_Sbox u_sb (
            .sbox_in    (sub_chunk[b*AES_BYTE_W +: AES_BYTE_W]),
            .aes128_sbox(fwd_chunk[b*AES_BYTE_W +: AES_BYTE_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chk_err_q <= 1'b0;
        else if (state_q == BUSY && fwd_chunk != cur_chunk)
            chk_err_q <= 1'b1;
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Scoreboard bench for inv_sub_bytes_iter: one instance per legal
// BYTES_PER_CYCLE (1,2,4,8,16); instance 2 is the BPC=4 default.
module tb_inv_sub_bytes_iter;
    localparam int NB = 5;
    localparam logic [127:0] KV_IN  = 128'h637C16ED_637C16ED_637C16ED_637C16ED;
    localparam logic [127:0] KV_OUT = 128'h0001FF53_0001FF53_0001FF53_0001FF53;
    localparam logic [0:255][7:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NB-1:0] in_valid, in_ready, out_valid, out_ready, busy, chk_err;
    logic [NB-1:0][127:0] in_state, out_state;
    int n_cmp = 0;
    int n_bad = 0;
    logic [127:0] sb_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NB; g++) begin : g_dut
        inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1 << g)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_state (in_state[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_state(out_state[g]),
            .busy     (busy[g]),
            .chk_err  (chk_err[g])
        );
    end

    // One transaction on instance i; junk=1 keeps in_valid high with a zero
    // state during BUSY to prove it is ignored.
    task automatic send(input int i, input logic [127:0] din, input logic [127:0] exp,
                        input int stall, input bit junk, input string name);
        int lat;
        int want_lat;
        logic [127:0] e;
        want_lat = 16 / (1 << i) + 1;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        in_valid[i] = 1'b1;
        in_state[i] = din;
        out_ready[i] = (stall == 0);
        @(negedge clk);
        n_cmp++;
        if (in_ready[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s[%0d] idle_in_ready: got %b want 1", name, i, in_ready[i]);
        end
        @(posedge clk); #1;
        if (junk) in_state[i] = '0;
        else in_valid[i] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (out_valid[i] !== 1'b1 && lat < 40) begin
            n_cmp++;
            if (in_ready[i] !== 1'b0 || busy[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL %s[%0d] busy_flags: in_ready=%b busy=%b want 0/1", name, i, in_ready[i], busy[i]);
            end
            @(negedge clk);
            lat++;
        end
        in_valid[i] = 1'b0;
        n_cmp++;
        if (lat != want_lat) begin
            n_bad++;
            $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, want_lat);
        end
        for (int s = 0; s < stall; s++) begin
            n_cmp++;
            if (out_valid[i] !== 1'b1 || in_ready[i] !== 1'b0 || busy[i] !== 1'b1 || out_state[i] !== exp) begin
                n_bad++;
                $display("FAIL %s[%0d] hold: valid=%b ready=%b state=%h want 1/0 %h", name, i,
                         out_valid[i], in_ready[i], out_state[i], exp);
            end
            @(negedge clk);
        end
        out_ready[i] = 1'b1;
        e = sb_q.pop_front();
        n_cmp++;
        if (out_state[i] !== e) begin
            n_bad++;
            $display("FAIL %s[%0d] data: got %h want %h", name, i, out_state[i], e);
        end
        n_cmp++;
        if (chk_err[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL %s[%0d] chk_err: got %b want 0", name, i, chk_err[i]);
        end
        @(negedge clk);
        out_ready[i] = 1'b0;
        n_cmp++;
        if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1 || busy[i] !== 1'b0 || out_state[i] !== e) begin
            n_bad++;
            $display("FAIL %s[%0d] to_idle: valid=%b ready=%b busy=%b state=%h want 0/1/0 %h", name, i,
                     out_valid[i], in_ready[i], busy[i], out_state[i], e);
        end
    endtask

    task automatic check_reset_vals(input string name);
        for (int i = 0; i < NB; i++) begin
            n_cmp++;
            if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || out_state[i] !== '0 ||
                busy[i] !== 1'b0 || chk_err[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL %s[%0d]: ready=%b valid=%b state=%h busy=%b err=%b want 1/0/0/0/0", name, i,
                         in_ready[i], out_valid[i], out_state[i], busy[i], chk_err[i]);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_known_vector();
        send(2, KV_IN, KV_OUT, 0, 1'b0, "known");
    endtask

    task automatic test_backpressure();
        send(2, KV_IN, KV_OUT, 10, 1'b0, "backpressure");
    endtask

    task automatic test_busy_ignore();
        send(2, KV_IN, KV_OUT, 2, 1'b1, "busy_ignore");
    endtask

    task automatic test_round_trip();
        logic [127:0] din, exp;
        for (int i = 0; i < NB; i++) begin
            for (int s = 0; s < 16; s++) begin
                for (int j = 0; j < 16; j++) begin
                    din[j*8 +: 8] = FWD[s*16 + j];
                    exp[j*8 +: 8] = 8'(s*16 + j);
                end
                send(i, din, exp, int'($urandom_range(0, 2)), 1'b0, "round_trip");
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clk); #1;
        in_valid[2] = 1'b1;
        in_state[2] = KV_IN;
        out_ready[2] = 1'b0;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (busy[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_busy_precheck: busy got %b want 1", busy[2]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_mid_busy");
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(2, KV_IN, KV_OUT, 0, 1'b0, "after_reset");
    endtask

    task automatic test_chk();
`ifdef AES_INV_SUB_CHECK_EN
        force g_dut[2].u_dut.g_sbox[0].u_isb.aes128_inv_sbox = 8'h53;
        @(posedge clk); #1;
        in_valid[2] = 1'b1;
        in_state[2] = '0;
        out_ready[2] = 1'b1;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        release g_dut[2].u_dut.g_sbox[0].u_isb.aes128_inv_sbox;
        out_ready[2] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (chk_err[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL chk_sticky: got %b want 1", chk_err[2]);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (chk_err[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL chk_cleared: got %b want 0", chk_err[2]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
`else
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            n_cmp++;
            if (chk_err[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL chk_tied_off[%0d]: got %b want 0", i, chk_err[i]);
            end
        end
`endif
    endtask

    initial begin
        in_valid  = '0;
        out_ready = '0;
        in_state  = '0;
        test_reset();
        test_known_vector();
        test_backpressure();
        test_busy_ignore();
        test_round_trip();
        test_reset_mid_busy();
        test_chk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
